present_key_sched_bidir: RTL and testbench
==========================================

// Module: present_key_sched_bidir
// PURPOSE
//  Parametrised PRESENT round-key engine for 80- or 128-bit keys, serving the shared enc/dec datapath.
//  Expands a cipher key into ROUNDS+1 64-bit round keys and caches them in a register array.
//  Streams the keys over a valid/ready port: forward for encryption, reverse for decryption.
//  A cached schedule can be replayed in either direction without re-expansion.
// PARAMETERS
//  KEY_W   128  key width; legal values are 80 and 128
//  ROUNDS  31   number of update steps; range 1..31; produces ROUNDS+1 round keys
// PORTS
//  clk       in   1      single clock; all logic is posedge
//  rst_n     in   1      synchronous, active-low reset
//  key       in   KEY_W  cipher key; sampled on an accepted start
//  start     in   1      request a schedule; accepted only in IDLE
//  mode      in   1      0 = encrypt (forward, K1 first); 1 = decrypt (reverse, K[ROUNDS+1] first)
//  reuse     in   1      1 = replay the cache (key ignored); honoured only if cache_valid = 1
//  rk        out  64     current round key; 0 when rk_valid = 0
//  rk_idx    out  6      index of rk (1..ROUNDS+1); 0 when rk_valid = 0
//  rk_valid  out  1      rk and rk_idx are valid
//  rk_ready  in   1      consumer accepts rk this cycle
//  rk_last   out  1      rk_valid and this is the final key in the current direction
//  busy      out  1      state is not IDLE
//  done      out  1      one-cycle pulse on the cycle after the final handshake
//  cache_ok  out  1      the cache holds a complete schedule
// BEHAVIOUR
//  Reset (rst_n = 0 at posedge) sets:
//   state = IDLE; rk_valid, busy, done and cache_ok = 0; ctr = 0; kreg = 0.
//   Cache contents are don't-care.
//  Key update step with counter c (c = ctr[4:0]):
//   KEY_W = 80:  kreg = kreg <<< 61; [79:76] = S([79:76]); [19:15] ^= c.
//   KEY_W = 128: kreg = kreg <<< 61; [127:124] = S([127:124]); [123:120] = S([123:120]); [66:62] ^= c.
//   S is the PRESENT S-box: C56B90AD3EF84712.
//   Round key K_i = kreg[KEY_W-1 -: 64] after i-1 update steps.
//  FSM states: IDLE, ENC, EXPAND, STREAM.
//  IDLE. On start:
//   Latch mode.
//   If reuse && cache_ok: go to STREAM. ctr = 1 if mode = 0, otherwise ROUNDS+1.
//   Otherwise: kreg = key; ctr = 1; cache_ok = 0; go to ENC if mode = 0, EXPAND if mode = 1.
//  ENC:
//   rk = K_ctr, rk_valid = 1.
//   On handshake: cache[ctr] = rk; kreg = update(kreg, ctr); ctr++.
//   On handshake with ctr = ROUNDS+1: cache_ok = 1, done = 1 next cycle, go to IDLE.
//  EXPAND (rk_valid = 0):
//   Each cycle: cache[ctr] = top64(kreg); kreg = update(kreg, ctr); ctr++.
//   After storing ctr = ROUNDS+1: cache_ok = 1, ctr stays ROUNDS+1, go to STREAM.
//  STREAM:
//   rk = cache[ctr], rk_valid = 1.
//   On handshake, ctr steps +1 (mode 0) or -1 (mode 1).
//   Last key is ROUNDS+1 (mode 0) or 1 (mode 1). After its handshake: done = 1 next cycle, go to IDLE.
//  Latency from start sampled at cycle T to first rk_valid:
//   ENC or reuse: T+1.
//   Fresh decrypt: T+ROUNDS+2, i.e. ROUNDS+1 EXPAND cycles.
//  Stalls: while rk_valid && !rk_ready, rk, rk_idx and rk_last hold stable. No key is skipped or repeated.
//  start while busy is ignored; key, mode and reuse are don't-care then.
//  Reset mid-operation aborts immediately and clears cache_ok.
//   A later reuse request is then treated as fresh.
//  An ENC run clears cache_ok until its final key is accepted (the cache is partially overwritten).
// TESTING
//  T1: KEY_W=80, key=0, mode=0, rk_ready=1.
//      -> K1=0000000000000000, K2=C000000000000000, idx 1..32.
//      -> rk_last on idx 32; done 1 cycle later; cache_ok=1.
//  T2: KEY_W=128, key=0, mode=1.
//      -> rk_valid first at T+33 with idx 32 = golden-model K32.
//      -> Sequence continues 31..1; idx 2 = CC00000000000000; idx 1 = 0 with rk_last.
//  T3: random rk_ready duty (about 30% low) in both modes.
//      -> rk/rk_idx stable across stalls; exactly 32 distinct handshakes, all matching the golden model.
//  T4: after T1, start mode=1 reuse=1.
//      -> rk_valid at T+1, no EXPAND; sequence equals T1 reversed.
//  T5: assert rst_n=0 during EXPAND (cycle 10).
//      -> next cycle: busy=0, rk_valid=0, cache_ok=0.
//      -> A following reuse=1 start runs a full expansion (first rk at T+33).
//  T6: pulse start while busy; then start reuse=1 with cache_ok=0.
//      -> First start is ignored; the second performs a fresh schedule from key.

Source files
------------

// File: rtl/present_key_sched_bidir.sv
// PRESENT round-key engine (80/128-bit keys): expands a key into ROUNDS+1 round keys,
// caches them, and streams them forward (encrypt) or reverse (decrypt) over valid/ready.
module present_key_sched_bidir #(
  parameter int KEY_W  = 128,
  parameter int ROUNDS = 31
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [KEY_W-1:0] key,
  input  logic             start,
  input  logic             mode,
  input  logic             reuse,
  output logic [63:0]      rk,
  output logic [5:0]       rk_idx,
  output logic             rk_valid,
  input  logic             rk_ready,
  output logic             rk_last,
  output logic             busy,
  output logic             done,
  output logic             cache_ok
);

  if (!(KEY_W == 80 || KEY_W == 128) || ROUNDS < 1 || ROUNDS > 31) begin : g_param_check
    $error("present_key_sched_bidir: KEY_W must be 80 or 128 and ROUNDS 1..31");
  end

  typedef enum logic [1:0] {
    IDLE,
    ENC,
    EXPAND,
    STREAM
  } state_t;

  localparam logic [5:0] LP_LAST = 6'(ROUNDS + 1);

  function automatic logic [3:0] f_sbox(input logic [3:0] n);
    logic [3:0] s;
    case (n)
      4'h0: s = 4'hC;
      4'h1: s = 4'h5;
      4'h2: s = 4'h6;
      4'h3: s = 4'hB;
      4'h4: s = 4'h9;
      4'h5: s = 4'h0;
      4'h6: s = 4'hA;
      4'h7: s = 4'hD;
      4'h8: s = 4'h3;
      4'h9: s = 4'hE;
      4'hA: s = 4'hF;
      4'hB: s = 4'h8;
      4'hC: s = 4'h4;
      4'hD: s = 4'h7;
      4'hE: s = 4'h1;
      default: s = 4'h2;
    endcase
    return s;
  endfunction

  function automatic logic [KEY_W-1:0] f_update(input logic [KEY_W-1:0] k,
                                                input logic [4:0]       c);
    logic [KEY_W-1:0] r;
    r = {k[KEY_W-62:0], k[KEY_W-1:KEY_W-61]};
    r[KEY_W-1 -: 4] = f_sbox(r[KEY_W-1 -: 4]);
    if (KEY_W == 128) begin
      r[KEY_W-5 -: 4] = f_sbox(r[KEY_W-5 -: 4]);
      r[66:62]        = r[66:62] ^ c;
    end else begin
      r[19:15] = r[19:15] ^ c;
    end
    return r;
  endfunction

  state_t           r_state, w_state_nxt;
  logic [5:0]       r_ctr, w_ctr_nxt;
  logic [KEY_W-1:0] r_kreg, w_kreg_nxt;
  logic             r_cache_ok, w_cok_nxt;
  logic             r_mode, w_mode_nxt;
  logic             r_done, w_done_nxt;
  logic             w_we;
  logic             w_valid;
  logic             w_hs;
  logic             w_last;
  logic [4:0]       w_cidx;
  logic [63:0]      w_top;
  logic [63:0]      r_cache [0:31];

  // Round key i lives in slot i-1; index 32 wraps to slot 31 in five bits.
  assign w_cidx  = r_ctr[4:0] - 5'd1;
  assign w_top   = r_kreg[KEY_W-1 -: 64];
  assign w_valid = (r_state == ENC) || (r_state == STREAM);
  assign w_hs    = w_valid && rk_ready;
  assign w_last  = (r_state == STREAM && r_mode) ? (r_ctr == 6'd1) : (r_ctr == LP_LAST);

  always_comb begin
    w_state_nxt = r_state;
    w_ctr_nxt   = r_ctr;
    w_kreg_nxt  = r_kreg;
    w_cok_nxt   = r_cache_ok;
    w_mode_nxt  = r_mode;
    w_done_nxt  = 1'b0;
    w_we        = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_mode_nxt = mode;
          if (reuse && r_cache_ok) begin
            w_state_nxt = STREAM;
            w_ctr_nxt   = mode ? LP_LAST : 6'd1;
          end else begin
            w_kreg_nxt  = key;
            w_ctr_nxt   = 6'd1;
            w_cok_nxt   = 1'b0;
            w_state_nxt = mode ? EXPAND : ENC;
          end
        end
      end
      ENC: begin
        if (w_hs) begin
          w_we       = 1'b1;
          w_kreg_nxt = f_update(r_kreg, r_ctr[4:0]);
          if (r_ctr == LP_LAST) begin
            w_cok_nxt   = 1'b1;
            w_done_nxt  = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_ctr_nxt = r_ctr + 6'd1;
          end
        end
      end
      EXPAND: begin
        w_we = 1'b1;
        // Counter parks on the last index so STREAM starts there in reverse.
        if (r_ctr == LP_LAST) begin
          w_cok_nxt   = 1'b1;
          w_state_nxt = STREAM;
        end else begin
          w_kreg_nxt = f_update(r_kreg, r_ctr[4:0]);
          w_ctr_nxt  = r_ctr + 6'd1;
        end
      end
      STREAM: begin
        if (w_hs) begin
          if (w_last) begin
            w_done_nxt  = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_ctr_nxt = r_mode ? (r_ctr - 6'd1) : (r_ctr + 6'd1);
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_ctr      <= '0;
      r_kreg     <= '0;
      r_cache_ok <= 1'b0;
      r_mode     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ctr      <= w_ctr_nxt;
      r_kreg     <= w_kreg_nxt;
      r_cache_ok <= w_cok_nxt;
      r_mode     <= w_mode_nxt;
      r_done     <= w_done_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && w_we) begin
      r_cache[w_cidx] <= w_top;
    end
  end

  always_comb begin
    rk = '0;
    if (r_state == ENC) begin
      rk = w_top;
    end else if (r_state == STREAM) begin
      rk = r_cache[w_cidx];
    end
  end

  assign rk_idx   = w_valid ? r_ctr : 6'd0;
  assign rk_valid = w_valid;
  assign rk_last  = w_valid && w_last;
  assign busy     = (r_state != IDLE);
  assign done     = r_done;
  assign cache_ok = r_cache_ok;

endmodule

// File: tb/tb_present_key_sched_bidir.sv
// Scoreboard bench for present_key_sched_bidir: one 80-bit and one 128-bit instance,
// expected key streams come from a behavioural key-schedule model.
module tb_present_key_sched_bidir;

  typedef struct packed {
    logic        inst;
    logic [5:0]  idx;
    logic [63:0] rk;
    logic        last;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n    [2];
  logic        start    [2];
  logic        mode     [2];
  logic        reuse    [2];
  logic        rk_ready [2];
  logic [63:0] rk       [2];
  logic [5:0]  rk_idx   [2];
  logic        rk_valid [2];
  logic        rk_last  [2];
  logic        busy     [2];
  logic        done     [2];
  logic        cache_ok [2];
  logic [79:0]  key80;
  logic [127:0] key128;

  int checks   = 0;
  int failures = 0;
  int ready_pct = 100;
  exp_t q[$];
  bit           model_cok  [2];
  logic [127:0] model_ckey [2];

  present_key_sched_bidir #(.KEY_W(80), .ROUNDS(31)) u_k80 (
    .clk(clk), .rst_n(rst_n[0]), .key(key80), .start(start[0]), .mode(mode[0]),
    .reuse(reuse[0]), .rk(rk[0]), .rk_idx(rk_idx[0]), .rk_valid(rk_valid[0]),
    .rk_ready(rk_ready[0]), .rk_last(rk_last[0]), .busy(busy[0]), .done(done[0]),
    .cache_ok(cache_ok[0])
  );

  present_key_sched_bidir #(.KEY_W(128), .ROUNDS(31)) u_k128 (
    .clk(clk), .rst_n(rst_n[1]), .key(key128), .start(start[1]), .mode(mode[1]),
    .reuse(reuse[1]), .rk(rk[1]), .rk_idx(rk_idx[1]), .rk_valid(rk_valid[1]),
    .rk_ready(rk_ready[1]), .rk_last(rk_last[1]), .busy(busy[1]), .done(done[1]),
    .cache_ok(cache_ok[1])
  );

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  function automatic logic [3:0] sbox_m(input logic [3:0] n);
    logic [63:0] t;
    t = 64'hC56B90AD3EF84712;
    return t[63 - 4*int'(n) -: 4];
  endfunction

  // Round key idx = top 64 bits after idx-1 update steps, computed on a 128-bit container.
  function automatic logic [63:0] model_rk(input int kw, input logic [127:0] key, input int idx);
    logic [127:0] k, mask;
    logic [3:0]   nib;
    int           sh;
    mask = (kw == 80) ? {48'h0, {80{1'b1}}} : {128{1'b1}};
    k = key & mask;
    for (int r = 1; r < idx; r++) begin
      k = ((k << 61) | (k >> (kw - 61))) & mask;
      for (int n = 0; n < ((kw == 80) ? 1 : 2); n++) begin
        sh  = kw - 4 - 4*n;
        nib = 4'((k >> sh) & 128'hF);
        k   = (k & ~(128'hF << sh)) | (128'(sbox_m(nib)) << sh);
      end
      k = k ^ (128'(r) << ((kw == 80) ? 15 : 62));
    end
    return 64'(k >> (kw - 64));
  endfunction

  task automatic drive_key(input int i, input logic [127:0] k);
    if (i == 0) key80 = k[79:0];
    else        key128 = k;
  endtask

  task automatic rst_inst(input int i);
    rst_n[i] = 1'b0;
    start[i] = 1'b0;
    @(posedge clk); #1;
    rst_n[i] = 1'b1;
    chk("reset_busy", busy[i], 0);
    chk("reset_rk_valid", rk_valid[i], 0);
    chk("reset_cache_ok", cache_ok[i], 0);
    chk("reset_done", done[i], 0);
    q.delete();
    model_cok[i] = 1'b0;
  endtask

  // One schedule request; poke_at pulses a junk start mid-run, abort_at resets mid-run.
  task automatic run_sched(input int i, input bit md, input bit ru, input logic [127:0] k,
                           input int poke_at, input int abort_at);
    logic [127:0] ekey;
    bit   fresh, got_done;
    int   exp_lat, cyc, first, idx, kw;
    exp_t e;
    kw      = (i == 0) ? 80 : 128;
    fresh   = !(ru && model_cok[i]);
    ekey    = fresh ? k : model_ckey[i];
    if (kw == 80) ekey = {48'h0, ekey[79:0]};
    exp_lat = (fresh && md) ? 33 : 1;
    q.delete();
    for (int n = 1; n <= 32; n++) begin
      idx    = md ? 33 - n : n;
      e.inst = i[0];
      e.idx  = 6'(idx);
      e.last = (n == 32);
      if (ekey == 0 && idx == 1)      e.rk = 64'h0;
      else if (ekey == 0 && idx == 2) e.rk = (kw == 80) ? 64'hC000000000000000 : 64'hCC00000000000000;
      else                            e.rk = model_rk(kw, ekey, idx);
      q.push_back(e);
    end
    drive_key(i, k);
    mode[i]  = md;
    reuse[i] = ru;
    start[i] = 1'b1;
    @(posedge clk); #1;
    start[i] = 1'b0;
    mode[i]  = 1'($urandom);
    reuse[i] = 1'($urandom);
    drive_key(i, {$urandom, $urandom, $urandom, $urandom});
    if (fresh) model_cok[i] = 1'b0;
    chk("cache_ok_after_start", cache_ok[i], fresh ? 0 : 1);
    chk("busy_after_start", busy[i], 1);
    cyc = 1; first = 0; got_done = 1'b0;
    while (cyc < 400 && !got_done) begin
      if (cyc == abort_at) begin
        chk("busy_before_abort", busy[i], 1);
        rst_inst(i);
        return;
      end
      if (first == 0 && rk_valid[i]) begin
        first = cyc;
        chk("first_rk_latency", first, exp_lat);
      end
      if (poke_at > 0 && cyc == poke_at) begin
        start[i] = 1'b1;
        mode[i]  = ~md;
        reuse[i] = 1'($urandom);
        drive_key(i, {$urandom, $urandom, $urandom, $urandom});
      end
      if (poke_at > 0 && cyc == poke_at + 1) start[i] = 1'b0;
      if (done[i]) got_done = 1'b1;
      else begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    if (!got_done) begin
      checks++;
      failures++;
      $display("FAIL done_timeout inst=%0d actual=no_done required=done", i);
    end else begin
      chk("all_keys_consumed", q.size(), 0);
      chk("cache_ok_at_done", cache_ok[i], 1);
      chk("idle_at_done", busy[i], 0);
      model_cok[i]  = 1'b1;
      model_ckey[i] = ekey;
    end
  endtask

  initial begin
    rk_ready[0] = 1'b1;
    rk_ready[1] = 1'b1;
    forever begin
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) rk_ready[i] = ($urandom_range(99) < ready_pct);
    end
  end

  bit          p_stall  [2];
  bit          p_lasths [2];
  logic [63:0] p_rk     [2];
  logic [5:0]  p_idx    [2];
  logic        p_last   [2];

  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      if (!rst_n[i]) begin
        p_stall[i]  = 1'b0;
        p_lasths[i] = 1'b0;
      end else begin
        if (done[i] || p_lasths[i]) chk("done_pulse", done[i], p_lasths[i]);
        if (!rk_valid[i]) chk("invalid_outputs_zero", {rk[i], rk_idx[i], rk_last[i]}, 0);
        if (p_stall[i])
          chk("stall_hold", {rk_valid[i], rk[i], rk_idx[i], rk_last[i]},
              {1'b1, p_rk[i], p_idx[i], p_last[i]});
        if (rk_valid[i] && rk_ready[i]) begin
          if (q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_hs inst=%0d actual=idx%0d required=no_handshake", i, rk_idx[i]);
          end else begin
            e = q.pop_front();
            chk("hs_key", {i[0], rk_idx[i], rk[i], rk_last[i]}, {e.inst, e.idx, e.rk, e.last});
          end
        end
        p_stall[i]  = rk_valid[i] && !rk_ready[i];
        p_lasths[i] = rk_valid[i] && rk_ready[i] && rk_last[i];
        p_rk[i]     = rk[i];
        p_idx[i]    = rk_idx[i];
        p_last[i]   = rk_last[i];
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [127:0] rk_key;
    key80  = '0;
    key128 = '0;
    for (int i = 0; i < 2; i++) begin
      rst_n[i] = 1'b0;
      start[i] = 1'b0;
      mode[i]  = 1'b0;
      reuse[i] = 1'b0;
      model_cok[i]  = 1'b0;
      model_ckey[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      rst_n[i] = 1'b1;
      chk("init_busy", busy[i], 0);
      chk("init_rk_valid", rk_valid[i], 0);
      chk("init_cache_ok", cache_ok[i], 0);
      chk("init_rk_idx", rk_idx[i], 0);
    end

    run_sched(0, 1'b0, 1'b0, '0, 0, 0);
    run_sched(0, 1'b1, 1'b1, {$urandom, $urandom, $urandom, $urandom}, 0, 0);
    run_sched(1, 1'b1, 1'b0, '0, 0, 0);

    ready_pct = 70;
    for (int t = 0; t < 2; t++) begin
      rk_key = {$urandom, $urandom, $urandom, $urandom};
      run_sched(0, 1'b0, 1'b0, rk_key, 0, 0);
      run_sched(0, 1'b1, 1'b1, rk_key, 0, 0);
      rk_key = {$urandom, $urandom, $urandom, $urandom};
      run_sched(1, 1'b1, 1'b0, rk_key, 0, 0);
      run_sched(1, 1'b0, 1'b1, rk_key, 0, 0);
    end

    run_sched(1, 1'b1, 1'b0, {$urandom, $urandom, $urandom, $urandom}, 0, 10);
    run_sched(1, 1'b1, 1'b1, {$urandom, $urandom, $urandom, $urandom}, 0, 0);
    run_sched(1, 1'b0, 1'b1, '0, 0, 12);
    run_sched(1, 1'b0, 1'b1, {$urandom, $urandom, $urandom, $urandom}, 0, 0);

    rst_inst(0);
    run_sched(0, 1'b0, 1'b1, {$urandom, $urandom, $urandom, $urandom}, 5, 0);
    run_sched(0, 1'b1, 1'b0, {$urandom, $urandom, $urandom, $urandom}, 7, 0);
    run_sched(1, 1'b1, 1'b1, '0, 20, 0);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
